// File: rtl/ram_burst_rd_sw.sv
// ram_burst_rd_sw: single-write, LANES-word burst-read RAM with a valid/ready output stage.
// Define RD_FWD_EN to make a same-cycle write to a word in the granted burst visible in that burst (write-first).
module ram_burst_rd_sw #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 7,
   parameter int RAM_DEPTH  = 96,
   parameter int LANES      = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        wr_en,
   input  logic [ADDR_WIDTH-1:0]       wr_addr,
   input  logic [DATA_WIDTH-1:0]       wr_data,
   output logic                        wr_done,
   output logic                        wr_err,
   input  logic                        rd_req,
   input  logic [ADDR_WIDTH-1:0]       rd_addr,
   output logic                        rd_gnt,
   output logic                        rd_valid,
   input  logic                        rd_ready,
   output logic [LANES*DATA_WIDTH-1:0] rd_data,
   output logic                        rd_err,
   output logic [ADDR_WIDTH:0]         hw_mark,
   output logic                        fm
);
   logic [DATA_WIDTH-1:0]       r_mem [RAM_DEPTH];
   logic [LANES*DATA_WIDTH-1:0] w_lanes;
   logic                        w_wr_ok;
   logic                        w_rd_legal;

   assign w_wr_ok    = wr_en && ({1'b0, wr_addr} < (ADDR_WIDTH+1)'(RAM_DEPTH));
   // Range test is done one bit wider so a base near the top cannot wrap into a legal burst.
   assign w_rd_legal = ({1'b0, rd_addr} + (ADDR_WIDTH+1)'(LANES)) <= (ADDR_WIDTH+1)'(RAM_DEPTH);
   assign rd_gnt     = rst_n && rd_req && (!rd_valid || rd_ready);
   assign fm         = hw_mark == (ADDR_WIDTH+1)'(RAM_DEPTH);

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      logic [ADDR_WIDTH-1:0] w_idx;
      assign w_idx = rd_addr + ADDR_WIDTH'(k);
`ifdef RD_FWD_EN
      assign w_lanes[k*DATA_WIDTH +: DATA_WIDTH] = (w_wr_ok && wr_addr == w_idx) ? wr_data : r_mem[w_idx];
`else
      assign w_lanes[k*DATA_WIDTH +: DATA_WIDTH] = r_mem[w_idx];
`endif
   end

   always_ff @(posedge clk) begin
      if (rst_n && w_wr_ok) r_mem[wr_addr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_done  <= 1'b0;
         wr_err   <= 1'b0;
         hw_mark  <= '0;
         rd_valid <= 1'b0;
         rd_err   <= 1'b0;
         rd_data  <= '0;
      end else begin
         wr_done <= w_wr_ok;
         wr_err  <= wr_en && !w_wr_ok;
         if (w_wr_ok && ({1'b0, wr_addr} >= hw_mark)) hw_mark <= {1'b0, wr_addr} + 1'b1;
         if (rd_gnt) begin
            rd_valid <= 1'b1;
            rd_err   <= !w_rd_legal;
            rd_data  <= w_rd_legal ? w_lanes : '0;
         end else if (rd_ready) begin
            rd_valid <= 1'b0;
         end
      end
   end
endmodule
